// File: rtl/sevenseg_pkg.sv
// Shared types and constant helpers for the 7-segment sequence player.
//   DISPLAY_OFF     digit code that blanks every segment
//   bcd_digit_t     one BCD digit (4 bits)
//   player_state_t  sequence player FSM states
//   bcd_digits_for  decimal digit count needed for 2^value_w-1
//   pow10           10^n, used for the overflow threshold
//   idx_width       max(1, clog2(digits)), width of the digit index
package sevenseg_pkg;

  localparam logic [3:0] DISPLAY_OFF = 4'd10;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_SHOW,
    ST_OFF,
    ST_FIN
  } player_state_t;

  // Value widths are limited to 16 bits, so six divisions always suffice.
  function automatic int bcd_digits_for(input int value_w);
    int max_val;
    int n;
    max_val = (1 << value_w) - 1;
    n = 1;
    for (int i = 0; i < 6; i++) begin
      if (max_val > 9) begin
        max_val = max_val / 10;
        n++;
      end
    end
    return n;
  endfunction

  function automatic int pow10(input int n);
    int p;
    p = 1;
    for (int i = 0; i < n; i++) begin
      p = p * 10;
    end
    return p;
  endfunction

  function automatic int idx_width(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/sevenseg_sequence_player_if.sv
// Handshake/display bundle of the sequence player.
//   start, value, trigger : requester -> player
//   seg, digit_idx, busy, done, overflow : player -> requester
// master = requester side, slave = player side.
interface sevenseg_sequence_player_if
  import sevenseg_pkg::*;
#(
  parameter int VALUE_W = 8,
  parameter int DIGITS  = 3
);

  localparam int IDX_W = idx_width(DIGITS);

  logic               start;
  logic [VALUE_W-1:0] value;
  logic               trigger;
  logic [6:0]         seg;
  logic [IDX_W-1:0]   digit_idx;
  logic               busy;
  logic               done;
  logic               overflow;

  modport master (
    output start, value, trigger,
    input  seg, digit_idx, busy, done, overflow
  );

  modport slave (
    input  start, value, trigger,
    output seg, digit_idx, busy, done, overflow
  );

endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary to BCD converter, one bit per clock.
//   clk, rst : clock and synchronous active-high reset
//   load     : latch bin and perform the first conversion step
//   bin      : binary input
//   busy     : steps still outstanding after the load cycle
//   bcd      : BCD result, valid once busy is low
// A full conversion takes VALUE_W steps: the first happens on the load edge,
// the remaining VALUE_W-1 on the following edges.
module bin2bcd_seq
  import sevenseg_pkg::*;
#(
  parameter int VALUE_W    = 8,
  parameter int DIGITS_INT = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [VALUE_W-1:0]      bin,
  output logic                    busy,
  output logic [4*DIGITS_INT-1:0] bcd
);

  localparam int CNT_W = $clog2(VALUE_W + 1);
  localparam int BCD_W = 4 * DIGITS_INT;

  logic [VALUE_W-1:0] shreg;
  logic [CNT_W-1:0]   steps_left;
  logic [BCD_W-1:0]   adjusted;

  // Add-3 correction of every nibble that would reach 10+ after the shift.
  always_comb begin
    bcd_digit_t nib;
    adjusted = bcd;
    for (int i = 0; i < DIGITS_INT; i++) begin
      nib = bcd[4*i +: 4];
      if (nib >= 4'd5) begin
        adjusted[4*i +: 4] = nib + 4'd3;
      end
    end
  end

  // On load the BCD register is zero, so the first step needs no correction
  // and simply takes the input MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg      <= '0;
      bcd        <= '0;
      steps_left <= '0;
    end else if (load) begin
      bcd        <= {{(BCD_W-1){1'b0}}, bin[VALUE_W-1]};
      shreg      <= bin << 1;
      steps_left <= CNT_W'(VALUE_W - 1);
    end else if (steps_left != '0) begin
      bcd        <= {adjusted[BCD_W-2:0], shreg[VALUE_W-1]};
      shreg      <= shreg << 1;
      steps_left <= steps_left - CNT_W'(1);
    end
  end

  assign busy = (steps_left != '0);

endmodule

// File: rtl/sevenseg_decoder.sv
// BCD digit to 7-segment pattern, active-high, seg[0]=a ... seg[6]=g.
//   digit : 0..9 lights the numeral, any other code (DISPLAY_OFF) blanks
//   seg   : segment pattern
module sevenseg_decoder
  import sevenseg_pkg::*;
(
  input  bcd_digit_t digit,
  output logic [6:0] seg
);

  always_comb begin
    case (digit)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/sevenseg_sequence_player.sv
// Plays a binary value as decimal digits, MSD first, on one 7-segment output,
// followed by a blank slot and a one-cycle done pulse.
//   clk, rst       : clock and synchronous active-high reset
//   bus.start      : latch bus.value and begin (ignored while busy)
//   bus.value      : binary value to play
//   bus.trigger    : advance pulse
//   bus.seg        : registered segment pattern
//   bus.digit_idx  : index of the digit being shown (0 = MSD), 0 elsewhere
//   bus.busy       : high from the cycle after start through the done cycle
//   bus.done       : one-cycle end-of-sequence pulse
//   bus.overflow   : latched value exceeds 10^DIGITS-1
// Parameters: VALUE_W input width, DIGITS played digits, HOLD_CYCLES
// auto-advance period (0 = trigger only), BLANK_LZ skip leading zeros.
module sevenseg_sequence_player
  import sevenseg_pkg::*;
#(
  parameter int VALUE_W     = 8,
  parameter int DIGITS      = 3,
  parameter int HOLD_CYCLES = 0,
  parameter int BLANK_LZ    = 1
) (
  input logic                     clk,
  input logic                     rst,
  sevenseg_sequence_player_if.slave bus
);

  localparam int DIGITS_INT = bcd_digits_for(VALUE_W);
  localparam int DIGITS_EXT = (DIGITS > DIGITS_INT) ? DIGITS : DIGITS_INT;
  localparam int BCD_EXT_W  = 4 * DIGITS_EXT;
  localparam int IDX_W      = idx_width(DIGITS);
  localparam int HOLD_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DIGITS - 1);
  localparam logic [31:0]       OVF_LIMIT = 32'(pow10(DIGITS));

  player_state_t         state;
  logic [IDX_W-1:0]      idx;
  logic [HOLD_W-1:0]     hold_cnt;
  logic                  busy_r;
  logic                  done_r;
  logic                  ovf_r;
  logic [6:0]            seg_r;

  logic                  conv_load;
  logic                  conv_busy;
  logic [4*DIGITS_INT-1:0] conv_bcd;
  logic [BCD_EXT_W-1:0]  bcd_ext;

  logic [IDX_W-1:0]      first_idx;
  bcd_digit_t            shown_digit;
  bcd_digit_t            seg_code;
  logic [6:0]            dec_seg;
  logic                  hold_expired;
  logic                  advance;
  logic                  in_play;

  // Start is only honoured in IDLE, which is exactly when busy is low.
  assign conv_load = (state == ST_IDLE) && bus.start;

  bin2bcd_seq #(
    .VALUE_W    (VALUE_W),
    .DIGITS_INT (DIGITS_INT)
  ) u_bin2bcd (
    .clk  (clk),
    .rst  (rst),
    .load (conv_load),
    .bin  (bus.value),
    .busy (conv_busy),
    .bcd  (conv_bcd)
  );

  // Widen so DIGITS larger than the converter's digit count reads zeros.
  assign bcd_ext = BCD_EXT_W'(conv_bcd);

  // Digit i (0 = MSD) of the played window sits at nibble DIGITS-1-i.
  // The descending scan leaves the lowest-index nonzero digit selected;
  // an all-zero value falls back to the least significant digit.
  always_comb begin
    first_idx = LAST_IDX;
    if ((BLANK_LZ != 0) && !ovf_r) begin
      for (int i = DIGITS - 1; i >= 0; i--) begin
        if (bcd_ext[4*(DIGITS-1-i) +: 4] != 4'd0) begin
          first_idx = IDX_W'(i);
        end
      end
    end else begin
      first_idx = '0;
    end
  end

  always_comb begin
    shown_digit = DISPLAY_OFF;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        shown_digit = bcd_ext[4*(DIGITS-1-i) +: 4];
      end
    end
  end

  // A trigger coinciding with timer expiry is still a single advance.
  assign in_play      = (state == ST_SHOW) || (state == ST_OFF);
  assign hold_expired = (HOLD_CYCLES > 0) && (hold_cnt == HOLD_LAST);
  assign advance      = in_play && (bus.trigger || hold_expired);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      idx      <= '0;
      hold_cnt <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;

      if (advance || !in_play) begin
        hold_cnt <= '0;
      end else begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end

      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state  <= ST_CONVERT;
            busy_r <= 1'b1;
            ovf_r  <= ({{(32-VALUE_W){1'b0}}, bus.value} >= OVF_LIMIT);
          end
        end
        ST_CONVERT: begin
          if (!conv_busy) begin
            state <= ST_SHOW;
            idx   <= first_idx;
          end
        end
        ST_SHOW: begin
          if (advance) begin
            if (idx == LAST_IDX) begin
              state <= ST_OFF;
              idx   <= '0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        ST_OFF: begin
          if (advance) begin
            state  <= ST_FIN;
            done_r <= 1'b1;
          end
        end
        ST_FIN: begin
          state  <= ST_IDLE;
          busy_r <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          idx    <= '0;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  // The display lags the FSM by one edge: the pattern is registered from
  // the state and index already held in flops.
  assign seg_code = (state == ST_SHOW) ? shown_digit : DISPLAY_OFF;

  sevenseg_decoder u_decoder (
    .digit (seg_code),
    .seg   (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_r <= 7'h00;
    end else begin
      seg_r <= dec_seg;
    end
  end

  assign bus.seg       = seg_r;
  assign bus.digit_idx = idx;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.overflow  = ovf_r;

endmodule
